// File: rtl/unified_mem_arbiter.sv
`timescale 1ns/1ps
// Shares one single-ported fixed-latency memory between the fetch and data ports.
// Define ARB_PERF_CNT_EN to add saturating per-port stall-cycle counters.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned LAT        = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [31:0]       if_rdata_o,
  output logic              if_valid_o,
  output logic              if_stall_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  input  logic [3:0]        d_xfer_size_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_valid_o,
  output logic              d_stall_o,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]       if_stall_cycles_o,
  output logic [31:0]       d_stall_cycles_o,
`endif
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_xfer_size_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]    LAST_CNT   = CNT_W'(LAT - 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  typedef enum logic [1:0] {S_IDLE, S_D_ACC, S_I_ACC} state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        size;
  } mem_cmd_t;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                mem_en_q, mem_en_d;
  mem_cmd_t            cmd_q, cmd_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                if_valid_q, if_valid_d;
  logic                d_valid_q, d_valid_d;

  // A port completing this cycle cannot be re-granted on the same request.
  logic d_req_m, if_req_m, starve_hit;
  assign d_req_m    = d_req_i & ~d_valid_q;
  assign if_req_m   = if_req_i & ~if_valid_q;
  assign starve_hit = (starve_q == STARVE_LIM);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      starve_q   <= '0;
      mem_en_q   <= 1'b0;
      cmd_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      mem_en_q   <= mem_en_d;
      cmd_q      <= cmd_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    mem_en_d   = mem_en_q;
    cmd_d      = cmd_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (d_req_m && !(if_req_m && starve_hit)) begin
          state_d  = S_D_ACC;
          cnt_d    = '0;
          mem_en_d = 1'b1;
          cmd_d    = '{we: d_we_i, addr: d_addr_i, wdata: d_wdata_i, size: d_xfer_size_i};
          if (if_req_m) starve_d = starve_hit ? starve_q : starve_q + STARVE_W'(1);
          else          starve_d = '0;
        end else if (if_req_m) begin
          state_d  = S_I_ACC;
          cnt_d    = '0;
          mem_en_d = 1'b1;
          cmd_d    = '{we: 1'b0, addr: if_addr_i, wdata: '0, size: 4'd0};
          starve_d = '0;
        end
      end
      S_D_ACC, S_I_ACC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          mem_en_d = 1'b0;
          if (state_q == S_D_ACC) begin
            d_valid_d = 1'b1;
            if (!cmd_q.we) d_rdata_d = mem_rdata_i;
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata_i[31:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign if_rdata_o      = if_rdata_q;
  assign if_valid_o      = if_valid_q;
  assign d_rdata_o       = d_rdata_q;
  assign d_valid_o       = d_valid_q;
  assign mem_en_o        = mem_en_q;
  assign mem_we_o        = cmd_q.we;
  assign mem_addr_o      = cmd_q.addr;
  assign mem_wdata_o     = cmd_q.wdata;
  assign mem_xfer_size_o = cmd_q.size;

  // Stalls are forced low while reset is held so every output reads 0 in reset.
  assign if_stall_o = rst_ni & if_req_i & ~if_valid_q;
  assign d_stall_o  = rst_ni & d_req_i & ~d_valid_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] if_stall_cnt_q, d_stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      if_stall_cnt_q <= '0;
      d_stall_cnt_q  <= '0;
    end else begin
      if (if_stall_o && !(&if_stall_cnt_q)) if_stall_cnt_q <= if_stall_cnt_q + 32'd1;
      if (d_stall_o && !(&d_stall_cnt_q))   d_stall_cnt_q  <= d_stall_cnt_q + 32'd1;
    end
  end

  assign if_stall_cycles_o = if_stall_cnt_q;
  assign d_stall_cycles_o  = d_stall_cnt_q;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for unified_mem_arbiter: vector table, directed corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_unified_mem_arbiter;

  localparam int unsigned LAT  = 2;
  localparam int unsigned SMAX = 4;
  localparam logic [63:0] DR   = 64'hFFFF_FEFF_8B02_0160;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [63:0] if_addr = 64'h40, d_addr = 64'h100, d_wdata = '0;
  logic [3:0]  d_size = '0;
  logic [31:0] if_rdata_o;
  logic        if_valid_o, if_stall_o, d_valid_o, d_stall_o;
  logic [63:0] d_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata;
  logic        mem_en_o, mem_we_o;
  logic [3:0]  mem_size_o;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] if_stall_cycles, d_stall_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Memory contents as a pure function of address.
  function automatic logic [63:0] mem_fn(input logic [63:0] a);
    return {~a[31:0], a[31:0] ^ 32'h8B02_0060};
  endfunction
  assign mem_rdata = mem_fn(mem_addr_o);

  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata_o),
    .if_valid_o(if_valid_o), .if_stall_o(if_stall_o),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_xfer_size_i(d_size), .d_rdata_o(d_rdata_o), .d_valid_o(d_valid_o), .d_stall_o(d_stall_o),
`ifdef ARB_PERF_CNT_EN
    .if_stall_cycles_o(if_stall_cycles), .d_stall_cycles_o(d_stall_cycles),
`endif
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_xfer_size_o(mem_size_o), .mem_rdata_i(mem_rdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst_n, if_req, d_req;
    logic        en, iv, dv, is, ds;
    logic [63:0] addr;
    logic [31:0] ifr;
    logic [63:0] dr;
  } vec_t;

  vec_t vecs[13];

  // Reference model state
  int          act_port;  // 0 none, 1 data, 2 fetch
  int          act_start, starve;
  logic        act_we;
  logic [63:0] act_addr, act_wdata, tmp;
  logic [3:0]  act_size;
  logic [31:0] m_ifr;
  logic [63:0] m_dr;

  task automatic new_d();
    d_req   = 1'b1;
    d_we    = 1'($urandom_range(1));
    d_addr  = {$urandom, $urandom};
    d_wdata = {$urandom, $urandom};
    d_size  = 4'($urandom_range(15));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_cnt, v_cnt;
    bit found, is_fetch;
    bit en, dv, iv;
    #1 rst_n = 1'b0;

    // rst, if, d | en, iv, dv, is, ds | addr | if_rdata | d_rdata
    vecs[0]  = '{0,0,1, 0,0,0,0,0, 64'h0,   32'h0,         64'h0};
    vecs[1]  = '{1,0,1, 0,0,0,0,1, 64'h0,   32'h0,         64'h0};
    vecs[2]  = '{1,0,1, 1,0,0,0,1, 64'h100, 32'h0,         64'h0};
    vecs[3]  = '{1,0,1, 1,0,0,0,1, 64'h100, 32'h0,         64'h0};
    vecs[4]  = '{1,0,1, 0,0,1,0,0, 64'h0,   32'h0,         DR};
    vecs[5]  = '{1,1,1, 0,0,0,1,1, 64'h0,   32'h0,         DR};
    vecs[6]  = '{1,1,1, 1,0,0,1,1, 64'h100, 32'h0,         DR};
    vecs[7]  = '{1,1,1, 1,0,0,1,1, 64'h100, 32'h0,         DR};
    vecs[8]  = '{1,1,1, 0,0,1,1,0, 64'h0,   32'h0,         DR};
    vecs[9]  = '{1,1,0, 1,0,0,1,0, 64'h40,  32'h0,         DR};
    vecs[10] = '{1,1,0, 1,0,0,1,0, 64'h40,  32'h0,         DR};
    vecs[11] = '{1,1,0, 0,1,0,0,0, 64'h0,   32'h8B02_0020, DR};
    vecs[12] = '{1,0,0, 0,0,0,0,0, 64'h0,   32'h8B02_0020, DR};

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; if_req = vecs[i].if_req; d_req = vecs[i].d_req;
      #1;
      chk($sformatf("vec%0d_mem_en", i),   64'(mem_en_o),   64'(vecs[i].en));
      chk($sformatf("vec%0d_if_valid", i), 64'(if_valid_o), 64'(vecs[i].iv));
      chk($sformatf("vec%0d_d_valid", i),  64'(d_valid_o),  64'(vecs[i].dv));
      chk($sformatf("vec%0d_if_stall", i), 64'(if_stall_o), 64'(vecs[i].is));
      chk($sformatf("vec%0d_d_stall", i),  64'(d_stall_o),  64'(vecs[i].ds));
      chk($sformatf("vec%0d_if_rdata", i), 64'(if_rdata_o), 64'(vecs[i].ifr));
      chk($sformatf("vec%0d_d_rdata", i),  d_rdata_o,       vecs[i].dr);
      if (vecs[i].en) chk($sformatf("vec%0d_mem_addr", i), mem_addr_o, vecs[i].addr);
    end

    // Store: command held for LAT cycles, d_rdata untouched, one valid pulse.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h200; d_wdata = 64'hDEAD_BEEF; d_size = 4'd8;
    en_cnt = 0; v_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      if (mem_en_o) begin
        en_cnt++;
        chk("store_mem_we",    64'(mem_we_o),   64'd1);
        chk("store_mem_wdata", mem_wdata_o,     64'hDEAD_BEEF);
        chk("store_mem_size",  64'(mem_size_o), 64'd8);
        chk("store_mem_addr",  mem_addr_o,      64'h200);
      end
      if (d_valid_o) begin v_cnt++; d_req = 1'b0; d_we = 1'b0; end
    end
    chk("store_en_cycles", 64'(en_cnt), 64'(LAT));
    chk("store_valid_cnt", 64'(v_cnt), 64'd1);
    chk("store_d_rdata",   d_rdata_o, DR);

    // Reset during the first data access cycle abandons it; re-grant after release.
    @(negedge clk);
    d_req = 1'b1; d_addr = 64'h300;
    @(negedge clk); #1;
    chk("rst_pre_mem_en", 64'(mem_en_o), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_mem_en", 64'(mem_en_o), 64'd0);
    @(negedge clk); #1;
    chk("rst_hold_d_valid", 64'(d_valid_o), 64'd0);
    chk("rst_hold_mem_en",  64'(mem_en_o),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    en_cnt = 0; v_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      if (mem_en_o) en_cnt++;
      if (d_valid_o) begin
        v_cnt++;
        chk("rst_regrant_rdata", d_rdata_o, mem_fn(64'h300));
        d_req = 1'b0;
      end
    end
    chk("rst_regrant_en_cycles", 64'(en_cnt), 64'(LAT));
    chk("rst_regrant_valid_cnt", 64'(v_cnt), 64'd1);

    // Starvation: fetch withdrawn on each data completion, so data wins SMAX times, then fetch.
    pulse_reset();
    if_addr = 64'h40;
    for (int k = 0; k <= int'(SMAX); k++) begin
      @(negedge clk);
      d_req = 1'b1; if_req = 1'b1; d_we = 1'b0; d_addr = 64'h1000 + 64'(8 * k);
      found = 0; is_fetch = 0;
      for (int c = 0; c < 4 && !found; c++) begin
        @(negedge clk); #1;
        if (mem_en_o) begin found = 1; is_fetch = (mem_addr_o == 64'h40); end
      end
      chk($sformatf("starve_grant_seen%0d", k), 64'(found), 64'd1);
      chk($sformatf("starve_grant_is_fetch%0d", k), 64'(is_fetch), 64'(k == int'(SMAX)));
      found = 0;
      for (int c = 0; c < 6 && !found; c++) begin
        @(negedge clk); #1;
        if (d_valid_o || if_valid_o) found = 1;
      end
      chk($sformatf("starve_done%0d", k), 64'(found), 64'd1);
      d_req = 1'b0; if_req = 1'b0;
    end

    // Randomized traffic against the reference model.
    pulse_reset();
    act_port = 0; act_start = 0; starve = 0; m_ifr = '0; m_dr = '0;
    act_we = 0; act_addr = '0; act_wdata = '0; act_size = '0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      en = (act_port != 0) && (t >= act_start) && (t < act_start + int'(LAT));
      dv = (act_port == 1) && (t == act_start + int'(LAT));
      iv = (act_port == 2) && (t == act_start + int'(LAT));
      tmp = mem_fn(act_addr);
      if (dv && !act_we) m_dr = tmp;
      if (iv) m_ifr = tmp[31:0];
      chk("rnd_mem_en",   64'(mem_en_o),   64'(en));
      chk("rnd_d_valid",  64'(d_valid_o),  64'(dv));
      chk("rnd_if_valid", 64'(if_valid_o), 64'(iv));
      chk("rnd_d_rdata",  d_rdata_o,       m_dr);
      chk("rnd_if_rdata", 64'(if_rdata_o), 64'(m_ifr));
      if (en) begin
        chk("rnd_mem_addr", mem_addr_o,     act_addr);
        chk("rnd_mem_we",   64'(mem_we_o),  64'(act_we));
        if (act_port == 1) begin
          chk("rnd_mem_wdata", mem_wdata_o,     act_wdata);
          chk("rnd_mem_size",  64'(mem_size_o), 64'(act_size));
        end
      end

      if (d_req) begin
        if (dv) begin
          if ($urandom_range(1) == 1) new_d(); else d_req = 1'b0;
        end else if (act_port == 1 && en) begin
          if ($urandom_range(15) == 0) d_req = 1'b0;
          else if ($urandom_range(3) == 0) d_addr = {$urandom, $urandom};
        end
      end else if ($urandom_range(2) == 0) new_d();

      if (if_req) begin
        if (iv) begin
          if ($urandom_range(1) == 1) if_addr = {$urandom, $urandom}; else if_req = 1'b0;
        end else if (act_port == 2 && en) begin
          if ($urandom_range(3) == 0) if_addr = {$urandom, $urandom};
        end else if ($urandom_range(7) == 0) if_req = 1'b0;
      end else if ($urandom_range(1) == 0) begin
        if_req = 1'b1; if_addr = {$urandom, $urandom};
      end
      #1;
      chk("rnd_d_stall",  64'(d_stall_o),  64'(d_req && !dv));
      chk("rnd_if_stall", 64'(if_stall_o), 64'(if_req && !iv));

      // Memory is free from the completion cycle onward.
      if (act_port == 0 || t >= act_start + int'(LAT)) begin
        if (d_req && !dv && !(if_req && !iv && starve == int'(SMAX))) begin
          starve   = (if_req && !iv) ? ((starve < int'(SMAX)) ? starve + 1 : starve) : 0;
          act_port = 1; act_start = t + 1; act_we = d_we; act_addr = d_addr;
          act_wdata = d_wdata; act_size = d_size;
        end else if (if_req && !iv) begin
          starve   = 0;
          act_port = 2; act_start = t + 1; act_we = 1'b0; act_addr = if_addr;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the pipeline's instruction-fetch port and data (load/store) port.
- Sequences each access over LAT cycles and returns read data with a one-cycle valid pulse.
- Produces per-port stall signals that freeze the IF stage or the MEM stage.
- Data port has priority; a starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 64, byte address width.
- DATA_W, 64, memory data width; fetch uses bits [31:0].
- LAT, 2, memory access cycles, legal range 1..15.
- STARVE_MAX, 4, consecutive data grants with fetch waiting before fetch is forced, minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request, level, held until if_valid.
- if_addr  in  ADDR_W  fetch address, stable while if_req.
- if_rdata  out  32  fetched instruction.
- if_valid  out  1  one-cycle completion pulse.
- if_stall  out  1  freeze IF stage.
- d_req  in  1  data request, level, held until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_xfer_size  in  4  transfer size, passed through.
- d_rdata  out  DATA_W  load data.
- d_valid  out  1  one-cycle completion pulse.
- d_stall  out  1  freeze MEM stage.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_xfer_size  out  4  memory transfer size.
- mem_rdata  in  DATA_W  memory read data, valid in the final access cycle.

Behaviour:
- Reset (reset low, asynchronous): state IDLE; all outputs 0; counters 0. mem_en drops immediately, so an in-flight access is abandoned and no valid pulse is issued.
- FSM states: IDLE, D_ACC, I_ACC.
- IDLE arbitration, requests sampled each cycle:
  - A port whose valid is high this cycle is masked.
  - Only d_req: go to D_ACC.
  - Only if_req: go to I_ACC.
  - Both requesting: go to D_ACC, unless starve_cnt == STARVE_MAX, then go to I_ACC.
  - Neither: stay in IDLE.
- Grant edge: register mem_en=1 and the address, we, wdata and xfer_size of the granted port. These are held constant for exactly LAT cycles. mem_we=0 for fetch. cnt=0.
- D_ACC / I_ACC: cnt increments each cycle. When cnt == LAT-1, the next edge:
  - captures mem_rdata into d_rdata (loads only; stores leave d_rdata unchanged) or mem_rdata[31:0] into if_rdata;
  - pulses the matching valid for one cycle;
  - clears mem_en and returns to IDLE.
- Latency: grant decided in cycle N; memory active cycles N+1..N+LAT; valid in cycle N+LAT+1.
- Back-to-back grants are possible from the valid cycle. Minimum period per access is LAT+1 cycles.
- rdata registers hold their value until the next completion on that port.
- starve_cnt:
  - +1 on each D_ACC grant while if_req is high, saturating at STARVE_MAX.
  - Cleared on each I_ACC grant, and cleared when if_req is low at a D_ACC grant.
- Stalls (combinational from registered state): if_stall = if_req & ~if_valid; d_stall = d_req & ~d_valid.
- Request dropped mid-access: the access still completes and valid still pulses; the requester ignores it.
- Address or data changes while in flight: no effect, because values were latched at grant.
- Simultaneous completion of one port and a new request from the other: the new request is granted in the IDLE/valid cycle.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined: adds output ports if_stall_cycles (32) and d_stall_cycles (32). Each increments on every cycle its stall signal is high, saturates at all-ones, and is cleared by reset.
- Undefined: these ports and counters do not exist. Arbitration behaviour is identical.

Test Plan:
- LAT=2. Reset low with d_req=1, then release reset → outputs stay 0 during reset. Grant on the first cycle after release; d_valid 3 cycles after the grant decision; mem_en high for exactly 2 cycles.
- Fetch only, if_addr=0x40, mem_rdata=0x00000000_8B020020 → if_rdata=0x8B020020. if_valid pulses once. if_stall is high for every earlier cycle of the request.
- Load and fetch requested in the same cycle → data granted first. Fetch granted on the d_valid cycle. if_valid comes LAT+1 cycles after d_valid.
- d_req held continuously with a new address after each completion, if_req held, STARVE_MAX=4 → grant sequence D,D,D,D,I,D,… and never 5 consecutive D grants.
- Store d_we=1, d_wdata=0xDEADBEEF, d_xfer_size=8 → mem_we=1 and mem_wdata/mem_xfer_size match for LAT cycles. d_rdata unchanged; d_valid pulses.
- Assert reset mid-D_ACC (cnt=0) → mem_en drops asynchronously. No d_valid. After release the pending d_req is re-granted and completes normally.
